// File: rtl/mod_exp_ctrl_if.sv
// Host and mon_prod signal bundle for the modular exponentiation sequencer.
// The controller takes the master modport and the host/mon_prod side takes the slave modport.
interface mod_exp_ctrl_if #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8
);
  // Handshakes: go is a one-cycle request honoured only while idle, and busy
  // stays high from acceptance until done. mp_start is a one-cycle request to
  // mon_prod. mp_stop is a level that is only trusted once the controller has
  // waited a cycle after mp_start, because it can still be high from the
  // previous op.
  logic                  go;
  logic [BITLEN-1:0]     exponent;
  logic [LOG_BITLEN:0]   exp_len;
  logic                  busy;
  logic                  done;
  logic                  mp_start;
  logic [1:0]            mp_op_code;
  logic [LOG_BITLEN:0]   mp_count;
  logic                  mp_stop;
  logic [LOG_BITLEN+1:0] n_ops;

  modport master (
    input  go, exponent, exp_len, mp_stop,
    output busy, done, mp_start, mp_op_code, mp_count, n_ops
  );

  modport slave (
    output go, exponent, exp_len, mp_stop,
    input  busy, done, mp_start, mp_op_code, mp_count, n_ops
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer that issues OPXX/OPXM/OPX1 to mon_prod.
// Square and multiply act on x_bar in memory; the closing OPX1 brings the result out of Montgomery form.
module mod_exp_ctrl #(
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int MP_COUNT   = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  mod_exp_ctrl_if.master      bus,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_SQ   = 2'd0,
    PH_MUL  = 2'd1,
    PH_CONV = 2'd2
  } phase_t;

  localparam logic [1:0]          OP_XX   = 2'd0;
  localparam logic [1:0]          OP_XM   = 2'd1;
  localparam logic [1:0]          OP_X1   = 2'd2;
  localparam logic [LOG_BITLEN:0] LEN_MAX = (LOG_BITLEN+1)'(BITLEN);

  state_t                state;
  phase_t                phase;
  logic [BITLEN-1:0]     e_reg;
  logic [LOG_BITLEN-1:0] bit_idx;
  logic [LOG_BITLEN:0]   exp_eff;
  logic [LOG_BITLEN-1:0] first_idx;

  // Lengths beyond the operand width are clamped so the top bit index stays in range.
  always_comb begin
    exp_eff   = (bus.exp_len > LEN_MAX) ? LEN_MAX : bus.exp_len;
    first_idx = LOG_BITLEN'(exp_eff - 1'b1);
  end

  assign bus.mp_count = (LOG_BITLEN+1)'(MP_COUNT);
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      phase          <= PH_SQ;
      e_reg          <= '0;
      bit_idx        <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.mp_start   <= 1'b0;
      bus.mp_op_code <= OP_XX;
      bus.n_ops      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.done <= 1'b0;
          if (bus.go) begin
            e_reg        <= bus.exponent;
            bus.busy     <= 1'b1;
            bus.n_ops    <= '0;
            bus.mp_start <= 1'b1;
            state        <= S_ISSUE;
            if (exp_eff == '0) begin
              bus.mp_op_code <= OP_X1;
              phase          <= PH_CONV;
            end else begin
              bit_idx        <= first_idx;
              bus.mp_op_code <= OP_XX;
              phase          <= PH_SQ;
            end
          end
        end

        S_ISSUE: begin
          bus.mp_start <= 1'b0;
          bus.n_ops    <= bus.n_ops + 1'b1;
          state        <= S_ARM;
        end

        // mp_stop may still be left over from the previous op, so it is not looked at here.
        S_ARM: state <= S_WAIT;

        S_WAIT: begin
          if (bus.mp_stop) state <= S_NEXT;
        end

        S_NEXT: begin
          if (phase == PH_CONV) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            bus.mp_start <= 1'b1;
            state        <= S_ISSUE;
            if (phase == PH_SQ && e_reg[bit_idx]) begin
              bus.mp_op_code <= OP_XM;
              phase          <= PH_MUL;
            end else if (bit_idx == '0) begin
              bus.mp_op_code <= OP_X1;
              phase          <= PH_CONV;
            end else begin
              bit_idx        <= bit_idx - 1'b1;
              bus.mp_op_code <= OP_XX;
              phase          <= PH_SQ;
            end
          end
        end

        S_DONE: begin
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a mon_prod stub that logs every issued op code.
// Each op takes 10 cycles with this stub, so a run of k ops reports done at negedge 10*k+1 after go.
module tb_mod_exp_ctrl;
  localparam int BITLEN = 256;
  localparam int LB     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_exp_ctrl_if #(.BITLEN(BITLEN), .LOG_BITLEN(LB)) bus ();
  logic [2:0] fsm_state;

  mod_exp_ctrl #(.BITLEN(BITLEN), .LOG_BITLEN(LB), .MP_COUNT(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] op_log[$];
  logic [1:0] exp_q[$];

  // mon_prod stub: samples start, drops stop one cycle later, raises it 6 cycles after that.
  logic stub_stop = 1'b1;
  logic start_seen = 1'b0;
  int   stub_cnt = 0;
  assign bus.mp_stop = stub_stop;

  always @(posedge clk) begin
    if (start_seen) begin
      stub_stop  <= 1'b0;
      stub_cnt   <= 6;
      start_seen <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_stop <= 1'b1;
    end
    if (bus.mp_start) begin
      start_seen <= 1'b1;
      op_log.push_back(bus.mp_op_code);
    end
  end

  int   done_cnt = 0;
  int   dbl_start = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.mp_start && prev_start) dbl_start++;
    prev_start = bus.mp_start;
  end

  task automatic do_go(input logic [BITLEN-1:0] e, input logic [LB:0] len);
    @(posedge clk); #1;
    bus.exponent = e;
    bus.exp_len  = len;
    bus.go       = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic wait_ops(input int n, input int budget, output bit ok);
    int c = 0;
    while (op_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (op_log.size() >= n);
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.exponent = '0; bus.exp_len = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.mp_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b want=0", bus.mp_start); end
    checks++; if (bus.mp_op_code !== 2'd0) begin errors++; $display("FAIL reset_op got=%0d want=0", bus.mp_op_code); end
    checks++; if (bus.n_ops !== 10'd0) begin errors++; $display("FAIL reset_nops got=%0d want=0", bus.n_ops); end
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", fsm_state); end
    checks++; if (bus.mp_count !== 9'd256) begin errors++; $display("FAIL mp_count got=%0d want=256", bus.mp_count); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit seen; int d0; int bad;
    op_log.delete(); exp_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    d0 = done_cnt;
    do_go(256'b1011, 9'd4);
    wait_done(2000, cyc, seen);
    checks++; if (!seen || cyc != 81) begin errors++; $display("FAIL basic_latency seen=%b cycles=%0d want=81", seen, cyc); end
    checks++; if (bus.n_ops !== 10'd8) begin errors++; $display("FAIL basic_nops got=%0d want=8", bus.n_ops); end
    bad = (op_log.size() != exp_q.size()) ? 99 : -1;
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++)
      if (bad < 0 && op_log[i] !== exp_q[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL basic_ops first_bad=%0d got_len=%0d want_len=%0d", bad, op_log.size(), exp_q.size()); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL basic_after_done busy=%b done=%b want 0 0", bus.busy, bus.done); end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++; if (dbl_start != 0) begin errors++; $display("FAIL basic_start_width got=%0d double starts want=0", dbl_start); end
  endtask

  task automatic test_zero_len();
    int cyc; bit seen;
    op_log.delete();
    do_go({$urandom, $urandom, 192'h0, $urandom, $urandom}, 9'd0);
    wait_done(500, cyc, seen);
    checks++; if (!seen || cyc != 11) begin errors++; $display("FAIL zero_len_latency seen=%b cycles=%0d want=11", seen, cyc); end
    checks++; if (bus.n_ops !== 10'd1) begin errors++; $display("FAIL zero_len_nops got=%0d want=1", bus.n_ops); end
    checks++; if (op_log.size() != 1 || op_log[0] !== 2'd2) begin errors++; $display("FAIL zero_len_ops got_len=%0d want single X1", op_log.size()); end
  endtask

  task automatic test_zero_exp();
    int cyc; bit seen; int bad;
    op_log.delete(); exp_q.delete();
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd2};
    do_go(256'h0, 9'd3);
    wait_done(1000, cyc, seen);
    checks++; if (!seen || cyc != 41) begin errors++; $display("FAIL zero_exp_latency seen=%b cycles=%0d want=41", seen, cyc); end
    checks++; if (bus.n_ops !== 10'd4) begin errors++; $display("FAIL zero_exp_nops got=%0d want=4", bus.n_ops); end
    bad = (op_log.size() != exp_q.size()) ? 99 : -1;
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++)
      if (bad < 0 && op_log[i] !== exp_q[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL zero_exp_ops first_bad=%0d got_len=%0d", bad, op_log.size()); end
  endtask

  task automatic test_long();
    int cyc; bit seen; int bad;
    logic [BITLEN-1:0] e;
    e = '0; e[BITLEN-1] = 1'b1;
    op_log.delete(); exp_q.delete();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    for (int i = 0; i < 255; i++) exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    do_go(e, 9'd300);
    wait_done(4000, cyc, seen);
    checks++; if (!seen || cyc != 2581) begin errors++; $display("FAIL long_latency seen=%b cycles=%0d want=2581", seen, cyc); end
    checks++; if (bus.n_ops !== 10'd258) begin errors++; $display("FAIL long_nops got=%0d want=258", bus.n_ops); end
    bad = (op_log.size() != exp_q.size()) ? 9999 : -1;
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++)
      if (bad < 0 && op_log[i] !== exp_q[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL long_ops first_bad=%0d got_len=%0d want_len=258", bad, op_log.size()); end
  endtask

  task automatic test_go_ignored();
    int cyc; bit seen; bit ok; int bad;
    op_log.delete(); exp_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    do_go(256'b1011, 9'd4);
    wait_ops(3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL go_ign_reach_op3 got=%0d ops want>=3", op_log.size()); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.exponent = '0; bus.exp_len = 9'd1; bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    wait_done(2000, cyc, seen);
    checks++; if (!seen || bus.n_ops !== 10'd8) begin errors++; $display("FAIL go_ign_nops seen=%b got=%0d want=8", seen, bus.n_ops); end
    repeat (30) @(negedge clk);
    bad = (op_log.size() != exp_q.size()) ? 99 : -1;
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++)
      if (bad < 0 && op_log[i] !== exp_q[i]) bad = i;
    checks++; if (bad >= 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL go_ign_ops first_bad=%0d got_len=%0d busy=%b want len 8 busy 0", bad, op_log.size(), bus.busy); end
  endtask

  task automatic test_arm_stop();
    int arm_hi = 0; int early = 0; int c = 0;
    logic [2:0] prev = 3'd0;
    op_log.delete();
    do_go(256'b1, 9'd1);
    while (!bus.done && c < 500) begin
      @(negedge clk);
      c++;
      if (fsm_state == 3'd2 && bus.mp_stop) arm_hi++;
      if (prev == 3'd2 && fsm_state != 3'd3) early++;
      if (prev == 3'd3 && fsm_state == 3'd4 && op_log.size() == 0) early++;
      prev = fsm_state;
    end
    checks++; if (arm_hi != 3) begin errors++; $display("FAIL arm_stop_high got=%0d ARM cycles with stop want=3", arm_hi); end
    checks++; if (early != 0 || !bus.done) begin errors++; $display("FAIL arm_early_next got=%0d done=%b want 0 1", early, bus.done); end
    checks++; if (bus.n_ops !== 10'd3 || op_log.size() != 3) begin errors++; $display("FAIL arm_nops got=%0d log=%0d want=3", bus.n_ops, op_log.size()); end
  endtask

  task automatic test_async_reset();
    int cyc; bit seen; bit ok; int bad; int c = 0;
    op_log.delete();
    do_go(256'b1011, 9'd4);
    wait_ops(2, 200, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || bus.busy !== 1'b1 || bus.mp_op_code !== 2'd1) begin errors++; $display("FAIL arst_pre busy=%b op=%0d want 1 1", bus.busy, bus.mp_op_code); end
    #2; rst_n = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mp_start !== 1'b0) begin errors++; $display("FAIL arst_flags busy=%b done=%b start=%b want 000", bus.busy, bus.done, bus.mp_start); end
    checks++; if (bus.mp_op_code !== 2'd0 || bus.n_ops !== 10'd0 || fsm_state !== 3'd0) begin errors++; $display("FAIL arst_regs op=%0d nops=%0d state=%0d want 0 0 0", bus.mp_op_code, bus.n_ops, fsm_state); end
    @(posedge clk); #1; rst_n = 1'b1;
    while (!stub_stop && c < 100) begin @(negedge clk); c++; end
    op_log.delete(); exp_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd2};
    do_go(256'b10, 9'd2);
    wait_done(1000, cyc, seen);
    checks++; if (!seen || bus.n_ops !== 10'd4) begin errors++; $display("FAIL arst_rerun_nops seen=%b got=%0d want=4", seen, bus.n_ops); end
    bad = (op_log.size() != exp_q.size()) ? 99 : -1;
    for (int i = 0; i < op_log.size() && i < exp_q.size(); i++)
      if (bad < 0 && op_log[i] !== exp_q[i]) bad = i;
    checks++; if (bad >= 0) begin errors++; $display("FAIL arst_rerun_ops first_bad=%0d got_len=%0d want_len=4", bad, op_log.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_zero_exp();
    test_long();
    test_go_ignored();
    test_arm_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
